// File: rtl/counter_bank.sv
// counter_bank: N_CH independent up/down counters sharing one prescaler,
// with wrap/saturate modes and one-cycle zero/compare/max event pulses.
//
// Ports:
//   sys_clk    : single clock, all state on posedge
//   reset      : synchronous, active-high
//   div_load   : prescaler reload value, tick period = div_load+1 cycles
//   ch_enable  : per-channel auto-count enable (counts on tick)
//   ch_clear   : per-channel clear (level, highest priority)
//   ch_up      : per-channel increment request
//   ch_down    : per-channel decrement request
//   ch_sat     : per-channel mode, 1 = saturate, 0 = wrap
//   cmp_value  : per-channel compare value, channel i at [i*WIDTH +: WIDTH]
//   count      : per-channel counter value, same packing
//   tick       : prescaler pulse, one cycle wide
//   ev_zero    : pulse when a count becomes 0
//   ev_cmp     : pulse when a count becomes equal to its cmp_value
//   ev_max     : pulse when a count becomes all-ones
module counter_bank #(
   parameter int N_CH      = 4,
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 24
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic [DIV_WIDTH-1:0]    div_load,
   input  logic [N_CH-1:0]         ch_enable,
   input  logic [N_CH-1:0]         ch_clear,
   input  logic [N_CH-1:0]         ch_up,
   input  logic [N_CH-1:0]         ch_down,
   input  logic [N_CH-1:0]         ch_sat,
   input  logic [N_CH*WIDTH-1:0]   cmp_value,
   output logic [N_CH*WIDTH-1:0]   count,
   output logic                    tick,
   output logic [N_CH-1:0]         ev_zero,
   output logic [N_CH-1:0]         ev_cmp,
   output logic [N_CH-1:0]         ev_max
);

   localparam logic [WIDTH-1:0] MaxVal = '1;

   // ---------------------------------------------------------------
   // Shared prescaler. div_load is only sampled on reload, so a new
   // value takes effect at the next wrap of the down-counter.
   // ---------------------------------------------------------------
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic                 tick_q, tick_d;

   always_comb begin
      div_d  = div_q - DIV_WIDTH'(1);
      tick_d = 1'b0;
      if (div_q == '0) begin
         div_d  = div_load;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         div_q  <= div_load;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

   // ---------------------------------------------------------------
   // Per-channel counter and edge-detected events
   // ---------------------------------------------------------------
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [WIDTH-1:0] cmp;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             inc, dec;
      logic             eq_zero, eq_cmp, eq_max;
      logic             pz_q, pc_q, pm_q;
      logic             ez_q, ec_q, em_q;

      assign cmp = cmp_value[i*WIDTH +: WIDTH];

      // up&down together cancel each other and also mask the tick
      assign dec = ch_down[i] & ~ch_up[i];
      assign inc = (ch_up[i] & ~ch_down[i])
                 | (~ch_up[i] & ~ch_down[i] & ch_enable[i] & tick_q);

      always_comb begin
         cnt_d = cnt_q;
         if (ch_clear[i]) begin
            cnt_d = '0;
         end else if (inc) begin
            if (!(ch_sat[i] && cnt_q == MaxVal))
               cnt_d = cnt_q + WIDTH'(1);
         end else if (dec) begin
            if (!(ch_sat[i] && cnt_q == '0))
               cnt_d = cnt_q - WIDTH'(1);
         end
      end

      // Equality is taken on the registered count, so events trail
      // the count change by one cycle and have no input-to-output path.
      assign eq_zero = (cnt_q == '0);
      assign eq_cmp  = (cnt_q == cmp);
      assign eq_max  = (cnt_q == MaxVal);

      always_ff @(posedge sys_clk) begin
         if (reset) begin
            cnt_q <= '0;
            // History matches the post-reset count of 0, so no
            // spurious zero (or zero-compare) event follows reset.
            pz_q  <= 1'b1;
            pc_q  <= (cmp == '0);
            pm_q  <= 1'b0;
            ez_q  <= 1'b0;
            ec_q  <= 1'b0;
            em_q  <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            pz_q  <= eq_zero;
            pc_q  <= eq_cmp;
            pm_q  <= eq_max;
            ez_q  <= eq_zero & ~pz_q;
            ec_q  <= eq_cmp & ~pc_q;
            em_q  <= eq_max & ~pm_q;
         end
      end

      assign count[i*WIDTH +: WIDTH] = cnt_q;
      assign ev_zero[i] = ez_q;
      assign ev_cmp[i]  = ec_q;
      assign ev_max[i]  = em_q;
   end

endmodule
